mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, meaning max cycles waiting for mem_ack before abort (range 1..255, 8-bit counter).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 f_req  input  1  fetch requester: request, held high until f_done.
REQ-005 f_addr  input  `DataBusBits  fetch address, stable while f_req high.
REQ-006 f_done  output  1  one-cycle pulse: fetch transaction complete.
REQ-007 d_req  input  1  data (load/store) requester: request, held high until d_done.
REQ-008 d_we  input  1  data write enable, stable while d_req high.
REQ-009 d_addr  input  `DataBusBits  data address (output of address generation), stable while d_req high.
REQ-010 d_wdata  input  `DataBusBits  store data, stable while d_req high.
REQ-011 d_be  input  4  store byte enables, stable while d_req high.
REQ-012 d_done  output  1  one-cycle pulse: data transaction complete.
REQ-013 rdata  output  `DataBusBits  registered read data, valid only in the f_done/d_done cycle.
REQ-014 err  output  1  asserted with f_done/d_done when the transaction timed out.
REQ-015 mem_req  output  1  memory request, held until mem_ack or timeout.
REQ-016 mem_we, mem_addr, mem_wdata, mem_be  output  1/`DataBusBits/`DataBusBits/4  registered copy of granted request.
REQ-017 mem_ack  input  1  memory completion, one cycle, any cycle >=1 after mem_req rises.
REQ-018 mem_rdata  input  `DataBusBits  read data, valid with mem_ack.

Function
REQ-019 FSM states SHALL be IDLE, BUSY, RESP; one outstanding transaction maximum.
REQ-020 IDLE: if any req sampled high, SHALL latch winner's fields into mem_* outputs, set mem_req=1, clear timeout counter, go BUSY next cycle; else stay IDLE.
REQ-021 Arbitration SHALL be round-robin on conflict: both requests high -> grant the requester not granted last; single request -> granted directly; last-granted flag resets to fetch (data wins first conflict).
REQ-022 Fetch grants SHALL drive mem_we=0, mem_wdata=0, mem_be=4'b1111.
REQ-023 BUSY with mem_ack=1: SHALL capture mem_rdata into rdata, drop mem_req, err=0, go RESP.
REQ-024 BUSY with mem_ack=0: counter SHALL increment; when counter reaches TIMEOUT, SHALL drop mem_req, set err=1, rdata=0, go RESP.
REQ-025 mem_ack and timeout in same cycle: ack SHALL win (err=0).
REQ-026 RESP: SHALL pulse exactly one of f_done/d_done (granted requester) for one cycle, ignore all requests, go IDLE next cycle.
REQ-027 Latency: request sampled at edge N -> mem_req high from N+1; ack sampled at edge M -> done high during M+1; earliest next grant sampled at M+2.
REQ-028 mem_ack outside BUSY SHALL be ignored.
REQ-029 A requester dropping req while granted SHALL NOT abort the transaction (protocol violation; done still issued).

Reset
REQ-030 On rst: state=IDLE, mem_req=0, all mem_* outputs=0, f_done=d_done=0, err=0, rdata=0, counter=0, last-granted=fetch.
REQ-031 rst asserted mid-transaction SHALL drop mem_req at next edge with no done pulse; in-flight mem_ack after reset ignored.

Structure
REQ-032 `DataBusBits and the FSM state encodings SHALL come from the shared defines header; no local redefinition.
REQ-033 One sub-module is natural: mem_rr_arbiter (2-way round-robin grant logic with last-granted flag); the rest stays flat.

Verification
REQ-034 Fetch only, f_addr=0x100, mem_ack 2 cycles after mem_req, mem_rdata=0xDEADBEEF -> mem_addr=0x100, mem_be=4'hF, f_done one cycle with rdata=0xDEADBEEF, err=0.
REQ-035 f_req and d_req both high from reset, held continuously -> grant order data, fetch, data, fetch; never both done in one cycle.
REQ-036 Store d_we=1, d_addr=0x2004, d_wdata=0x12345678, d_be=4'b0011 -> mem_* match exactly, d_done pulses, rdata ignored.
REQ-037 TIMEOUT=4, no mem_ack -> mem_req high 4 cycles in BUSY then low, d_done with err=1, rdata=0; ack on timeout cycle -> err=0.
REQ-038 rst asserted while BUSY then mem_ack one cycle after -> mem_req low, no done pulse, outputs at reset values, FSM IDLE.
REQ-039 Requester holds req through RESP cycle -> no re-grant in RESP; new transaction starts only from IDLE sample.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: data bus width, counter width and FSM states.
package mem_arbiter_pkg;

  localparam int unsigned DataBusBits = 32;
  localparam int unsigned CntBits     = 8;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp
  } state_e;

endpackage

// File: rtl/mem_rr_arbiter.sv
// Two-way round-robin grant between the fetch and data requesters.
module mem_rr_arbiter (
  input  logic clk,
  input  logic rst,
  input  logic f_req,
  input  logic d_req,
  input  logic grant_en,
  output logic any_req,
  output logic gnt_data
);

  // Remembers who won last; starts as fetch so data wins the first conflict.
  logic last_data_q;

  always_comb begin
    any_req  = f_req | d_req;
    gnt_data = d_req & (~f_req | ~last_data_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_data_q <= 1'b0;
    end else if (grant_en && any_req) begin
      last_data_q <= gnt_data;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding memory arbiter between fetch and data requesters, with ack timeout.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   f_req,
  input  logic [DataBusBits-1:0] f_addr,
  output logic                   f_done,
  input  logic                   d_req,
  input  logic                   d_we,
  input  logic [DataBusBits-1:0] d_addr,
  input  logic [DataBusBits-1:0] d_wdata,
  input  logic [3:0]             d_be,
  output logic                   d_done,
  output logic [DataBusBits-1:0] rdata,
  output logic                   err,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [DataBusBits-1:0] mem_addr,
  output logic [DataBusBits-1:0] mem_wdata,
  output logic [3:0]             mem_be,
  input  logic                   mem_ack,
  input  logic [DataBusBits-1:0] mem_rdata
);

  state_e                 state_q, state_d;
  logic [CntBits-1:0]     cnt_q, cnt_d;
  logic                   gnt_data_q, gnt_data_d;
  logic                   mem_req_q, mem_req_d;
  logic                   mem_we_q, mem_we_d;
  logic [DataBusBits-1:0] mem_addr_q, mem_addr_d;
  logic [DataBusBits-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]             mem_be_q, mem_be_d;
  logic [DataBusBits-1:0] rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic                   grant_en, any_req, gnt_data;

  mem_rr_arbiter u_rr (
    .clk      (clk),
    .rst      (rst),
    .f_req    (f_req),
    .d_req    (d_req),
    .grant_en (grant_en),
    .any_req  (any_req),
    .gnt_data (gnt_data)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_data_d  = gnt_data_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    grant_en    = 1'b0;
    case (state_q)
      StIdle: begin
        grant_en = 1'b1;
        if (any_req) begin
          gnt_data_d = gnt_data;
          mem_req_d  = 1'b1;
          cnt_d      = '0;
          state_d    = StBusy;
          if (gnt_data) begin
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            mem_be_d    = d_be;
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = f_addr;
            mem_wdata_d = '0;
            mem_be_d    = 4'b1111;
          end
        end
      end
      StBusy: begin
        if (mem_ack) begin
          rdata_d   = mem_rdata;
          err_d     = 1'b0;
          mem_req_d = 1'b0;
          state_d   = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CntBits'(TIMEOUT)) begin
            rdata_d   = '0;
            err_d     = 1'b1;
            mem_req_d = 1'b0;
            state_d   = StResp;
          end
        end
      end
      StResp: begin
        // err only qualifies the done pulse; clear it on the way back to idle.
        err_d   = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      gnt_data_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_data_q  <= gnt_data_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    f_done    = (state_q == StResp) && !gnt_data_q;
    d_done    = (state_q == StResp) && gnt_data_q;
    rdata     = rdata_q;
    err       = err_q;
    mem_req   = mem_req_q;
    mem_we    = mem_we_q;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    mem_be    = mem_be_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized transactions.
module tb_mem_arbiter;

  localparam int Tmo = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        f_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ack = 1'b0;
  logic [31:0] f_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic [3:0]  d_be = '0;
  logic        f_done, d_done, err, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  int vectors = 0;
  int miscompares = 0;
  bit last_data = 1'b0;  // reference: who won the previous grant

  mem_arbiter #(.TIMEOUT(Tmo)) dut (
    .clk       (clk),
    .rst       (rst),
    .f_req     (f_req),
    .f_addr    (f_addr),
    .f_done    (f_done),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_be      (d_be),
    .d_done    (d_done),
    .rdata     (rdata),
    .err       (err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_mem_be"}, 32'(mem_be), 32'd0);
    chk({tag, "_done"}, 32'({f_done, d_done}), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_rdata"}, rdata, 32'd0);
  endtask

  // One transaction from an idle DUT. ack_delay counts busy cycles before mem_ack;
  // ack_delay >= Tmo means memory never answers.
  task automatic run_txn(input int ack_delay, input bit hold_resp, input bit stray_ack,
                         input logic [31:0] rd_val);
    bit          win_d, acked;
    logic [31:0] e_addr, e_wdata, e_rd;
    logic [3:0]  e_be;
    logic        e_we;
    int          k;
    win_d     = (f_req && d_req) ? !last_data : d_req;
    last_data = win_d;
    e_addr    = win_d ? d_addr : f_addr;
    e_we      = win_d ? d_we : 1'b0;
    e_wdata   = win_d ? d_wdata : 32'd0;
    e_be      = win_d ? d_be : 4'hF;
    e_rd      = 32'd0;
    acked     = 1'b0;
    step();
    chk("grant_mem_addr", mem_addr, e_addr);
    chk("grant_mem_we", 32'(mem_we), 32'(e_we));
    chk("grant_mem_wdata", mem_wdata, e_wdata);
    chk("grant_mem_be", 32'(mem_be), 32'(e_be));
    k = 0;
    while (1) begin
      chk("busy_mem_req", 32'(mem_req), 32'd1);
      chk("busy_no_done", 32'({f_done, d_done}), 32'd0);
      if (k == ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = rd_val;
        e_rd      = rd_val;
        acked     = 1'b1;
      end
      step();
      mem_ack = 1'b0;
      k++;
      if (acked || k == Tmo) break;
    end
    chk("resp_f_done", 32'(f_done), win_d ? 32'd0 : 32'd1);
    chk("resp_d_done", 32'(d_done), win_d ? 32'd1 : 32'd0);
    chk("resp_err", 32'(err), acked ? 32'd0 : 32'd1);
    chk("resp_rdata", rdata, e_rd);
    chk("resp_mem_req", 32'(mem_req), 32'd0);
    if (stray_ack) mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("idle_done", 32'({f_done, d_done}), 32'd0);
    chk("idle_no_regrant", 32'(mem_req), 32'd0);
    if (!hold_resp) begin
      if (win_d) d_req = 1'b0;
      else f_req = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    last_data = 1'b0;
    chk_reset_outputs("reset");

    // Fetch read with the textbook response.
    f_req  = 1'b1;
    f_addr = 32'h100;
    run_txn(2, 1'b0, 1'b0, 32'hDEADBEEF);

    // Partial store.
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h2004;
    d_wdata = 32'h12345678;
    d_be    = 4'b0011;
    run_txn(1, 1'b0, 1'b1, 32'h0BAD_F00D);

    // Load timing out, then a load acked on the timeout cycle itself.
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h3000;
    d_be   = 4'hF;
    run_txn(Tmo, 1'b0, 1'b0, 32'h0);
    d_req = 1'b1;
    run_txn(Tmo - 1, 1'b0, 1'b0, 32'hCAFE_0001);

    // Both held continuously from reset: alternation starting with data.
    rst = 1'b1;
    step();
    rst = 1'b0;
    last_data = 1'b0;
    f_req  = 1'b1;
    f_addr = 32'h400;
    d_req  = 1'b1;
    d_addr = 32'h800;
    for (int i = 0; i < 4; i++) run_txn(i % 3, 1'b1, 1'b0, 32'h1000 + 32'(i));
    f_req = 1'b0;
    d_req = 1'b0;
    step();

    // Reset while busy, then a late ack that must be ignored.
    d_req  = 1'b1;
    d_addr = 32'h5555;
    step();
    chk("rstmid_busy", 32'(mem_req), 32'd1);
    rst   = 1'b1;
    d_req = 1'b0;
    step();
    rst       = 1'b0;
    last_data = 1'b0;
    chk_reset_outputs("rstmid");
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    step();
    mem_ack = 1'b0;
    chk_reset_outputs("late_ack");

    // Reset restored last-granted to fetch, so data wins this conflict.
    f_req = 1'b1;
    d_req = 1'b1;
    run_txn(0, 1'b0, 1'b0, 32'h7777);
    run_txn(3, 1'b0, 1'b0, 32'h8888);

    for (int n = 0; n < 60; n++) begin
      if (!f_req && ($urandom_range(0, 1) == 1)) begin
        f_req  = 1'b1;
        f_addr = $urandom;
      end
      if (!d_req && ($urandom_range(0, 1) == 1)) begin
        d_req   = 1'b1;
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = $urandom;
        d_wdata = $urandom;
        d_be    = 4'($urandom_range(0, 15));
      end
      if (f_req || d_req) begin
        run_txn(int'($urandom_range(0, Tmo)), $urandom_range(0, 3) == 0,
                $urandom_range(0, 1) == 1, $urandom);
      end else begin
        mem_ack = 1'($urandom_range(0, 1));
        step();
        mem_ack = 1'b0;
        chk("idle_quiet_req", 32'(mem_req), 32'd0);
        chk("idle_quiet_done", 32'({f_done, d_done}), 32'd0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
